// File: rtl/dma_req_responder.sv
// DMA request responder: queues {paddr,len,ctl} descriptors, expands each into BEAT_BYTES beats; first beat 2 cycles after accept, done 1 cycle after last beat.
// Backpressure: s_req_ready drops when the descriptor FIFO is full; m_beat_ready stalls hold the current beat stable.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
endmodule

module dma_req_responder #(
  parameter int PADDR_BITS = 64,
  parameter int LEN_BITS   = 28,
  parameter int BEAT_BYTES = 64,
  parameter int QDEPTH     = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_req_valid,
  output logic                      s_req_ready,
  input  logic [PADDR_BITS-1:0]     s_req_paddr,
  input  logic [LEN_BITS-1:0]       s_req_len,
  input  logic                      s_req_ctl,
  output logic                      s_rsp_done,
  output logic                      m_beat_valid,
  input  logic                      m_beat_ready,
  output logic [PADDR_BITS-1:0]     m_beat_addr,
  output logic                      m_beat_last,
  output logic [$clog2(QDEPTH):0]   outstanding
);
  localparam int OW    = $clog2(QDEPTH) + 1;
  localparam int SHIFT = $clog2(BEAT_BYTES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [LEN_BITS:0]   BEAT_ADD  = (LEN_BITS+1)'(BEAT_BYTES - 1);
  localparam logic [LEN_BITS:0]   BEATS_ONE = (LEN_BITS+1)'(1);
  localparam logic [PADDR_BITS-1:0] STEP    = PADDR_BITS'(BEAT_BYTES);
  localparam logic [OW-1:0]       OUT_ONE   = OW'(1);

  typedef struct packed {
    logic [PADDR_BITS-1:0] paddr;
    logic [LEN_BITS-1:0]   len;
    logic                  ctl;
  } desc_t;

  desc_t                 push_desc;
  desc_t                 head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  accept;
  logic                  load;
  logic                  beat_hs;
  logic                  last_hs;
  logic [LEN_BITS:0]     head_beats;
  logic                  head_zero;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [PADDR_BITS-1:0] addr;
  logic [LEN_BITS:0]     beats_left;
  logic                  ctl_r;
  logic                  done_r;
  logic [OW-1:0]         out_cnt;

  assign push_desc   = '{paddr: s_req_paddr, len: s_req_len, ctl: s_req_ctl};
  assign s_req_ready = !fifo_full && !areset;
  assign accept      = s_req_valid && s_req_ready;

  sync_fifo #(
    .WIDTH ($bits(desc_t)),
    .DEPTH (QDEPTH)
  ) u_desc_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (accept),
    .push_data (push_desc),
    .pop       (load),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // One extra bit keeps ceil(len/BEAT_BYTES) exact for len = all-ones.
  assign head_beats = ({1'b0, head.len} + BEAT_ADD) >> SHIFT;
  assign head_zero  = (head_beats == '0);

  assign load    = ((state == IDLE) || (state == DONE)) && !fifo_empty;
  assign beat_hs = (state == RUN) && m_beat_ready;
  assign last_hs = beat_hs && (beats_left == BEATS_ONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = head_zero ? DONE : RUN;
      RUN:  if (last_hs) state_nxt = DONE;
      DONE: state_nxt = load ? (head_zero ? DONE : RUN) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      addr       <= '0;
      beats_left <= '0;
      ctl_r      <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (load && head_zero && head.ctl) || (last_hs && ctl_r);
      if (load) begin
        addr       <= head.paddr;
        beats_left <= head_beats;
        ctl_r      <= head.ctl;
      end else if (beat_hs) begin
        addr       <= addr + STEP;
        beats_left <= beats_left - BEATS_ONE;
      end
    end
  end

  // Retirement happens in DONE, so an accept in the same cycle nets to zero.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_cnt <= '0;
    end else begin
      case ({accept, state == DONE})
        2'b10:   out_cnt <= out_cnt + OUT_ONE;
        2'b01:   out_cnt <= out_cnt - OUT_ONE;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  assign s_rsp_done   = done_r;
  assign m_beat_valid = (state == RUN);
  assign m_beat_addr  = addr;
  assign m_beat_last  = (state == RUN) && (beats_left == BEATS_ONE);
  assign outstanding  = out_cnt;
endmodule

// File: tb/tb_dma_req_responder.sv
// Directed bench for dma_req_responder: stimulus pushes expected beats/completions into queues,
// a negedge monitor pops and compares against what the DUT presents.

module tb_dma_req_responder;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        s_req_valid = 1'b0;
  logic        s_req_ready;
  logic [63:0] s_req_paddr = '0;
  logic [27:0] s_req_len = '0;
  logic        s_req_ctl = 1'b0;
  logic        s_rsp_done;
  logic        m_beat_valid;
  logic        m_beat_ready = 1'b0;
  logic [63:0] m_beat_addr;
  logic        m_beat_last;
  logic [3:0]  outstanding;

  dma_req_responder dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_req_valid  (s_req_valid),
    .s_req_ready  (s_req_ready),
    .s_req_paddr  (s_req_paddr),
    .s_req_len    (s_req_len),
    .s_req_ctl    (s_req_ctl),
    .s_rsp_done   (s_rsp_done),
    .m_beat_valid (m_beat_valid),
    .m_beat_ready (m_beat_ready),
    .m_beat_addr  (m_beat_addr),
    .m_beat_last  (m_beat_last),
    .outstanding  (outstanding)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] addr;
    logic        last;
  } beat_t;

  typedef struct {
    int total;
    bit timed;
  } done_t;

  beat_t exp_beats[$];
  done_t exp_done[$];
  int    exp_beat_total = 0;
  int    beats_seen = 0;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    last_hs_cyc = -10;
  bit    prev_stall = 0;
  logic [63:0] prev_addr = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every beat handshake and done pulse against the queues.
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 0;
    end else begin
      cyc++;
      if (prev_stall) begin
        check("stall_valid", m_beat_valid, 1);
        check("stall_addr", m_beat_addr, prev_addr);
        check("stall_last", m_beat_last, prev_last);
      end
      if (m_beat_valid && m_beat_ready) begin
        check("beat_expected", exp_beats.size() > 0, 1);
        if (exp_beats.size() > 0) begin
          beat_t b;
          b = exp_beats.pop_front();
          check("beat_addr", m_beat_addr, b.addr);
          check("beat_last", m_beat_last, b.last);
        end
        beats_seen++;
        if (m_beat_last) last_hs_cyc = cyc;
      end
      if (s_rsp_done) begin
        check("done_expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) begin
          done_t d;
          d = exp_done.pop_front();
          check("done_order", beats_seen, d.total);
          if (d.timed) check("done_latency", cyc, last_hs_cyc + 1);
        end
      end
      prev_stall = m_beat_valid && !m_beat_ready;
      prev_addr  = m_beat_addr;
      prev_last  = m_beat_last;
    end
  end

  task automatic send(input logic [63:0] pa, input logic [27:0] ln, input logic c);
    logic ok;
    int   n;
    s_req_valid = 1'b1;
    s_req_paddr = pa;
    s_req_len   = ln;
    s_req_ctl   = c;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge aclk);
      ok = s_req_ready;
      @(posedge aclk);
      #1;
    end
    s_req_valid = 1'b0;
    check("req_accepted", ok, 1);
    if (ok) begin
      n = int'((64'(ln) + 64'd63) / 64'd64);
      for (int k = 0; k < n; k++) begin
        beat_t b;
        b.addr = pa + 64'(k) * 64'd64;
        b.last = (k == n - 1);
        exp_beats.push_back(b);
      end
      exp_beat_total += n;
      if (c) begin
        done_t d;
        d.total = exp_beat_total;
        d.timed = (n > 0);
        exp_done.push_back(d);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 0;
    for (int t = 0; t < 500 && !idle; t++) begin
      @(posedge aclk);
      #1;
      idle = (exp_beats.size() == 0) && (exp_done.size() == 0) &&
             (outstanding == 0) && !m_beat_valid;
    end
    check(name, idle, 1);
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_ready", s_req_ready, 0);
    check("rst_beat_valid", m_beat_valid, 0);
    check("rst_done", s_rsp_done, 0);
    check("rst_addr", m_beat_addr, 0);
    check("rst_last", m_beat_last, 0);
    check("rst_outstanding", outstanding, 0);
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(posedge aclk);
    #1;
    check("post_rst_ready", s_req_ready, 1);

    // Single 4-beat descriptor with latency checks
    m_beat_ready = 1'b1;
    send(64'h1000, 28'd256, 1'b1);
    check("t1_no_bypass", m_beat_valid, 0);
    check("t1_outstanding", outstanding, 1);
    @(posedge aclk);
    #1;
    check("t1_first_valid", m_beat_valid, 1);
    check("t1_first_addr", m_beat_addr, 64'h1000);
    wait_idle("t1_idle");

    // len=65 -> 2 beats; len=0 -> no beats, done 2 cycles after accept
    send(64'h5000, 28'd65, 1'b1);
    wait_idle("t2_idle");
    send(64'h6000, 28'd0, 1'b1);
    check("t2z_done_c1", s_rsp_done, 0);
    @(posedge aclk);
    #1;
    check("t2z_done_c2", s_rsp_done, 1);
    check("t2z_no_beat", m_beat_valid, 0);
    @(posedge aclk);
    #1;
    check("t2z_done_c3", s_rsp_done, 0);
    wait_idle("t2z_idle");

    // Fill 8 stored + 1 working under beat stall
    m_beat_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(64'h2000 + 64'(i) * 64'h100, 28'd64, 1'b1);
    check("fill_ready_low", s_req_ready, 0);
    check("fill_outstanding", outstanding, 9);
    m_beat_ready = 1'b1;
    @(posedge aclk);
    #1;
    check("fill_ready_still_low", s_req_ready, 0);
    @(posedge aclk);
    #1;
    check("fill_ready_back", s_req_ready, 1);
    wait_idle("fill_idle");

    // ctl 1,0,1 with toggling beat ready
    fork
      begin
        send(64'h7000, 28'd128, 1'b1);
        send(64'h8000, 28'd128, 1'b0);
        send(64'h9000, 28'd128, 1'b1);
      end
      begin
        repeat (40) begin
          @(posedge aclk);
          #1;
          m_beat_ready = ~m_beat_ready;
        end
      end
    join
    m_beat_ready = 1'b1;
    wait_idle("mix_idle");

    // Address wrap
    send(64'hFFFF_FFFF_FFFF_FFC0, 28'd128, 1'b1);
    wait_idle("wrap_idle");

    // Reset during the 2nd beat of a 4-beat descriptor with 2 queued
    m_beat_ready = 1'b0;
    send(64'hA000, 28'd256, 1'b1);
    send(64'hB000, 28'd64, 1'b1);
    send(64'hC000, 28'd64, 1'b1);
    m_beat_ready = 1'b1;
    @(posedge aclk);
    #1;
    m_beat_ready = 1'b0;
    check("rst2_second_beat", m_beat_addr, 64'hA040);
    check("rst2_outstanding_pre", outstanding, 3);
    areset = 1'b1;
    #1;
    check("rst2_valid", m_beat_valid, 0);
    check("rst2_addr", m_beat_addr, 0);
    check("rst2_last", m_beat_last, 0);
    check("rst2_done", s_rsp_done, 0);
    check("rst2_ready", s_req_ready, 0);
    check("rst2_outstanding", outstanding, 0);
    exp_beats.delete();
    exp_done.delete();
    exp_beat_total = beats_seen;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    m_beat_ready = 1'b1;
    @(posedge aclk);
    #1;
    check("rst2_ready_after", s_req_ready, 1);
    check("rst2_outstanding_after", outstanding, 0);
    repeat (4) @(posedge aclk);
    #1;
    check("rst2_no_restart", m_beat_valid, 0);
    send(64'h3000, 28'd128, 1'b1);
    wait_idle("rst2_new_idle");

    repeat (3) @(posedge aclk);
    check("final_beats_drained", exp_beats.size(), 0);
    check("final_done_drained", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dma_req_responder.md
Name: dma_req_responder

Overview:
- Target-side endpoint for one dmaIntf request channel, such as the host or card request output of the TLB ISR arbiter.
- Buffers incoming DMA descriptors (paddr, len, ctl) in order and expands each into a stream of fixed-size beat commands toward the memory/data path.
- Emits a one-cycle rsp_done pulse per completed descriptor with ctl=1, strictly in acceptance order.
- Used as the engine front-end and as the bench responder for arbiter verification.

Parameters:
PADDR_BITS, 64, physical address width
LEN_BITS, 28, descriptor length width in bytes
BEAT_BYTES, 64, bytes per beat (power of two, >=1)
QDEPTH, 8, descriptor FIFO depth (power of two, >=2)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
s_req_valid  in  1  descriptor valid
s_req_ready  out  1  descriptor ready
s_req_paddr  in  PADDR_BITS  start address
s_req_len  in  LEN_BITS  length in bytes
s_req_ctl  in  1  completion requested
s_rsp_done  out  1  completion pulse (ctl=1 descriptors only)
m_beat_valid  out  1  beat command valid
m_beat_ready  in  1  beat command accepted
m_beat_addr  out  PADDR_BITS  beat address
m_beat_last  out  1  final beat of descriptor
outstanding  out  $clog2(QDEPTH)+1  descriptors accepted and not yet retired

Behaviour:
- Interface: one clock aclk; reset areset is asynchronous and active-high. All state clears immediately on assertion; the block resumes on the first aclk edge after deassertion.
- Reset values:
  - s_req_ready=0 while areset is high, 1 after reset (FIFO empty).
  - s_rsp_done=0, m_beat_valid=0, m_beat_last=0, m_beat_addr=0, outstanding=0.
- Descriptor accept:
  - Handshake on s_req_valid & s_req_ready. s_req_ready = !fifo_full, registered-free.
  - Accept when full is not allowed. Once valid is asserted, inputs must be held until ready; valid does not depend on ready.
- FIFO:
  - QDEPTH entries of {paddr, len, ctl}.
  - Push and pop in the same cycle when full: the push is rejected because ready=0. When empty, the push is stored and not bypassed.
- FSM states:
  - IDLE: FIFO non-empty -> pop head into working registers (addr, beats_left, ctl) -> RUN. beats_left = ceil(len/BEAT_BYTES), computed as (len + BEAT_BYTES-1) >> log2(BEAT_BYTES) at LEN_BITS+1 width, with no overflow at len = all-ones.
  - If the computed beats_left == 0 (len=0), go to DONE directly, emitting no beats.
  - RUN:
    - m_beat_valid=1; m_beat_addr=addr; m_beat_last=(beats_left==1).
    - On m_beat_ready: addr += BEAT_BYTES (modulo 2^PADDR_BITS wrap) and beats_left -= 1.
    - On the last-beat handshake -> DONE.
    - m_beat_addr and m_beat_last hold stable while valid & !ready.
  - DONE:
    - Single cycle. s_rsp_done = ctl (registered output, so the pulse is visible one cycle after the last-beat handshake). outstanding decrements.
    - Next state is IDLE; if the FIFO is non-empty, the head is popped in the same DONE cycle and the next state is RUN, giving one bubble cycle between descriptors.
- Latency:
  - Accept into an empty block -> first beat valid two cycles later (cycle 1 FIFO write, cycle 2 IDLE pop, beat visible in RUN).
  - Last-beat handshake -> s_rsp_done exactly one cycle later.
- outstanding: +1 on accept, -1 in DONE. Simultaneous events give a net 0. Range is 0..QDEPTH+1 (FIFO plus working descriptor), so the counter saturates at no value.
- ctl=0 descriptors: beats issue normally; no done pulse is emitted, but they are still retired from outstanding.
- Completion ordering: strictly acceptance order; no reordering.
- Reset mid-descriptor: beat stream aborts immediately (m_beat_valid drops asynchronously), queued descriptors are discarded, and no done pulse is emitted.
- Address is not page-aligned-checked; an unaligned paddr produces beats at paddr + k*BEAT_BYTES.

Test Plan:
- Single descriptor paddr=0x1000, len=256, ctl=1, m_beat_ready=1 -> 4 beats at 0x1000/0x1040/0x1080/0x10C0, last on the 4th; s_rsp_done high exactly one cycle after; outstanding 1->0.
- len=65, ctl=1 -> 2 beats (last on the 2nd). len=0, ctl=1 -> no beats; done pulse 2 cycles after accept.
- Fill with 9 descriptors of len=64 while m_beat_ready=0 -> 8 stored plus 1 working (s_req_ready=0 after the 9th accept), outstanding=9. Release ready -> 9 done pulses in order, s_req_ready reasserts after the first pop.
- Mix ctl=1,0,1 (len=128 each) with m_beat_ready toggling every cycle -> beat address/last stable under stall; exactly 2 done pulses, after the 1st and 3rd descriptors.
- paddr=0xFFFF_FFFF_FFFF_FFC0, len=128 -> second beat address wraps to 0x0.
- Assert areset during the 2nd beat of a 4-beat descriptor with 2 queued -> all outputs go to 0 immediately. After release: ready=1, outstanding=0, no done pulse; a new descriptor is processed normally.
